dc_stage: RTL and testbench

Data-cache-access pipeline stage between EX and MEM of the five-plus-stage MIPS core. It registers the EX result bus and checks load/store address alignment. It issues one request per memory instruction on the data SRAM-like request/response interface, holds the pipeline via `stallreq_dc` until the response arrives, and forms `dc_to_mem_bus` for MEM. MEM samples `data_sram_rdata` in the cycle this stage's instruction advances into it.

---
 rtl/dc_stage_pkg.sv | 65 ++++++
 rtl/dc_store_align.sv | 42 ++++
 rtl/dc_stage.sv | 141 ++++++++++++++
 tb/tb_dc_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_stage_pkg.sv
// Shared widths, bus layouts and field indices for the data-cache access stage.
// The packed structs give the EX->DC and DC->MEM bus layouts, MSB first.
package dc_stage_pkg;

    localparam int EX_TO_DC_WD  = 253;
    localparam int DC_TO_MEM_WD = 250;

    localparam int STALL_WD      = 7;
    localparam int STALL_IN_BIT  = 5;
    localparam int STALL_OUT_BIT = 6;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int EXC_ADES_BIT  = 14;
    localparam int EXC_ADEL_BIT  = 15;
    localparam int EXC_FETCH_BIT = 16;

    // mem_op is {lb, lbu, lh, lhu, lw}; store_op is {sb, sh, sw}
    localparam int LD_LW  = 0;
    localparam int LD_LHU = 1;
    localparam int LD_LH  = 2;
    localparam int LD_LBU = 3;
    localparam int LD_LB  = 4;
    localparam int ST_SW  = 0;
    localparam int ST_SH  = 1;
    localparam int ST_SB  = 2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [37:0] cp0_bus;
        logic        is_in_delayslot;
        logic [31:0] excepttype_arr;
        logic [4:0]  mem_op;
        logic [65:0] hilo_bus;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
        logic [2:0]  store_op;
        logic [31:0] rt_data;
    } ex_to_dc_t;

    typedef struct packed {
        logic [37:0] cp0_bus;
        logic        is_in_delayslot;
        logic [31:0] bad_vaddr;
        logic [31:0] excepttype_arr;
        logic [4:0]  mem_op;
        logic [65:0] hilo_bus;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
    } dc_to_mem_t;

endpackage

// File: rtl/dc_store_align.sv
// Combinational request attributes: access size, write strobes and lane-replicated
// store data from the memory-op one-hots and the low address bits.
module dc_store_align
    import dc_stage_pkg::*;
(
    input  logic [4:0]  mem_op,
    input  logic [2:0]  store_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rt_data,
    output logic        wr,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    always_comb begin
        wr    = |store_op;
        size  = SIZE_BYTE;
        wstrb = 4'b0000;
        wdata = 32'h0;
        if (store_op[ST_SB]) begin
            size  = SIZE_BYTE;
            wstrb = 4'b0001 << addr_lo;
            wdata = {4{rt_data[7:0]}};
        end else if (store_op[ST_SH]) begin
            size  = SIZE_HALF;
            wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rt_data[15:0]}};
        end else if (store_op[ST_SW]) begin
            size  = SIZE_WORD;
            wstrb = 4'b1111;
            wdata = rt_data;
        end else if (mem_op[LD_LB] | mem_op[LD_LBU]) begin
            size = SIZE_BYTE;
        end else if (mem_op[LD_LH] | mem_op[LD_LHU]) begin
            size = SIZE_HALF;
        end else if (mem_op[LD_LW]) begin
            size = SIZE_WORD;
        end
    end

endmodule

// File: rtl/dc_stage.sv
// Data-cache access stage between EX and MEM: stage register, alignment check,
// one SRAM-like request per memory instruction and a pipeline hold until its response.
module dc_stage
    import dc_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_DC_WD-1:0]  ex_to_dc_bus,
    output logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus,
    output logic                    stallreq_dc,
    output logic                    data_sram_req,
    output logic                    data_sram_wr,
    output logic [1:0]              data_sram_size,
    output logic [3:0]              data_sram_wstrb,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    input  logic                    data_sram_addr_ok,
    input  logic                    data_sram_data_ok
);

    // state     | meaning
    // ----------+---------------------------------------------------------
    // IDLE      | nothing in flight; request raised whenever acc is true
    // WAIT_DATA | request accepted, waiting for data_ok
    // DONE      | response delivered but downstream still stalled
    // DRAIN     | flushed with a request in flight; its data_ok is dropped
    typedef enum logic [1:0] {S_IDLE, S_WAIT_DATA, S_DONE, S_DRAIN} state_e;

    state_e     state;
    ex_to_dc_t  stage_q;
    dc_to_mem_t out_bus;
    logic       in_stop;
    logic       out_stop;
    logic [1:0] addr_lo;
    logic       mis_ld;
    logic       mis_st;
    logic       acc;
    logic [31:0] excepttype;
    logic [31:0] bad_vaddr;
    logic       unused_stall_lo;

    assign in_stop  = (stall[STALL_IN_BIT] == STOP);
    assign out_stop = (stall[STALL_OUT_BIT] == STOP);
    assign unused_stall_lo = ^stall[STALL_IN_BIT-1:0];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stage_q <= '0;
        end else if (in_stop && !out_stop) begin
            stage_q <= '0;
        end else if (!in_stop) begin
            stage_q <= ex_to_dc_bus;
        end
    end

    assign addr_lo = stage_q.alu_result[1:0];
    assign mis_ld  = ((stage_q.mem_op[LD_LH] | stage_q.mem_op[LD_LHU]) & addr_lo[0])
                   | (stage_q.mem_op[LD_LW] & (addr_lo != 2'b00));
    assign mis_st  = (stage_q.store_op[ST_SH] & addr_lo[0])
                   | (stage_q.store_op[ST_SW] & (addr_lo != 2'b00));

    // A fetch fault reported upstream owns bad_vaddr over any alignment fault here
    always_comb begin
        excepttype = stage_q.excepttype_arr;
        bad_vaddr  = 32'h0;
        excepttype[EXC_ADEL_BIT] = stage_q.excepttype_arr[EXC_ADEL_BIT] | mis_ld;
        excepttype[EXC_ADES_BIT] = stage_q.excepttype_arr[EXC_ADES_BIT] | mis_st;
        if (stage_q.excepttype_arr[EXC_FETCH_BIT]) begin
            bad_vaddr = stage_q.pc;
        end else if (mis_ld || mis_st) begin
            bad_vaddr = stage_q.alu_result;
        end
    end

    assign acc = stage_q.data_ram_en && (stage_q.pc != 32'h0) && (excepttype == 32'h0);

    // An accept coinciding with a flush still owes a response, so it is drained
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:
                    if (data_sram_req && data_sram_addr_ok)
                        state <= flush ? S_DRAIN : S_WAIT_DATA;
                S_WAIT_DATA:
                    if (data_sram_data_ok)
                        state <= (flush || !out_stop) ? S_IDLE : S_DONE;
                    else if (flush)
                        state <= S_DRAIN;
                S_DONE:
                    if (!out_stop || flush)
                        state <= S_IDLE;
                S_DRAIN:
                    if (data_sram_data_ok)
                        state <= S_IDLE;
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    assign data_sram_req = (state == S_IDLE) && acc;
    assign stallreq_dc   = acc && ((state == S_IDLE)
                                || ((state == S_WAIT_DATA) && !data_sram_data_ok)
                                || (state == S_DRAIN));
    assign data_sram_addr = stage_q.alu_result;

    dc_store_align u_store_align (
        .mem_op   (stage_q.mem_op),
        .store_op (stage_q.store_op),
        .addr_lo  (addr_lo),
        .rt_data  (stage_q.rt_data),
        .wr       (data_sram_wr),
        .size     (data_sram_size),
        .wstrb    (data_sram_wstrb),
        .wdata    (data_sram_wdata)
    );

    always_comb begin
        out_bus                 = '0;
        out_bus.cp0_bus         = stage_q.cp0_bus;
        out_bus.is_in_delayslot = stage_q.is_in_delayslot;
        out_bus.bad_vaddr       = bad_vaddr;
        out_bus.excepttype_arr  = excepttype;
        out_bus.mem_op          = stage_q.mem_op;
        out_bus.hilo_bus        = stage_q.hilo_bus;
        out_bus.pc              = stage_q.pc;
        out_bus.data_ram_en     = stage_q.data_ram_en;
        out_bus.data_ram_wen    = stage_q.data_ram_wen;
        out_bus.sel_rf_res      = stage_q.sel_rf_res;
        out_bus.rf_we           = stage_q.rf_we;
        out_bus.rf_waddr        = stage_q.rf_waddr;
        out_bus.alu_result      = stage_q.alu_result;
    end

    assign dc_to_mem_bus = out_bus;

endmodule

// File: tb/tb_dc_stage.sv
// Bench for dc_stage: directed scenarios then randomized traffic against a flag-based
// reference model, with a ctrl model deriving stall bits and a bridge model answering requests.
module tb_dc_stage;

    typedef struct packed {
        logic [37:0] cp0;
        logic        dslot;
        logic [31:0] exc;
        logic [4:0]  mem_op;
        logic [65:0] hilo;
        logic [31:0] pc;
        logic        en;
        logic [3:0]  wen;
        logic        sel;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [2:0]  st_op;
        logic [31:0] rt;
    } in_t;

    logic         clk = 1'b0;
    logic         rst, flush, ex_stop, ds_stop;
    logic [6:0]   stall;
    logic [252:0] ex_to_dc_bus;
    logic [249:0] dc_to_mem_bus;
    logic         stallreq_dc, data_sram_req, data_sram_wr;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic         addr_ok, data_ok;

    always #5 clk = ~clk;

    // ctrl: this stage's stall request freezes itself and everything upstream
    assign stall[6]   = stallreq_dc | ds_stop;
    assign stall[5]   = stall[6] | ex_stop;
    assign stall[4:0] = {5{stall[5]}};

    dc_stage dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .stall             (stall),
        .ex_to_dc_bus      (ex_to_dc_bus),
        .dc_to_mem_bus     (dc_to_mem_bus),
        .stallreq_dc       (stallreq_dc),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    in_t  m_reg;
    bit   pending, orphan, served, m_exp_req, cap_req;
    bit   br_busy;
    int   br_wait;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic in_t mk(input int kind, input logic [31:0] addr, input logic [31:0] rt,
                               input logic [31:0] pc, input logic [31:0] exc);
        in_t r;
        r        = '0;
        r.cp0    = {6'($urandom), $urandom};
        r.dslot  = 1'($urandom);
        r.exc    = exc;
        r.mem_op = (kind >= 1 && kind <= 5) ? 5'(5'b10000 >> (kind - 1)) : 5'b0;
        r.hilo   = {2'($urandom), $urandom, $urandom};
        r.pc     = pc;
        r.en     = (kind != 0);
        r.wen    = 4'($urandom);
        r.sel    = 1'($urandom);
        r.we     = 1'($urandom);
        r.waddr  = 5'($urandom);
        r.alu    = addr;
        r.st_op  = (kind >= 6 && kind <= 8) ? 3'(3'b100 >> (kind - 6)) : 3'b0;
        r.rt     = rt;
        return r;
    endfunction

    function automatic in_t rand_instr();
        int          kind;
        logic [31:0] a, pc, exc;
        kind = int'($urandom_range(0, 8));
        a    = $urandom;
        if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
        pc = 32'h8000_0000 | ($urandom & 32'h0fff_fffc);
        if ($urandom_range(0, 15) == 0) pc = 32'h0;
        exc = 32'h0;
        case ($urandom_range(0, 19))
            0, 1: exc[16] = 1'b1;
            2:    exc[$urandom_range(0, 31)] = 1'b1;
            default: ;
        endcase
        return mk(kind, a, $urandom, pc, exc);
    endfunction

    // Expected stage outputs computed from the captured instruction
    function automatic void expect_from(input in_t r, output logic [249:0] bus, output bit acc,
                                        output logic [1:0] size, output logic [3:0] strb,
                                        output logic [31:0] wdata, output bit wr);
        logic [31:0] a, exc, bad;
        bit          mis_ld, mis_st;
        a      = r.alu;
        mis_ld = ((r.mem_op[2] || r.mem_op[1]) && (a % 2) != 0) || (r.mem_op[0] && (a % 4) != 0);
        mis_st = (r.st_op[1] && (a % 2) != 0) || (r.st_op[0] && (a % 4) != 0);
        exc    = r.exc;
        if (mis_ld) exc[15] = 1'b1;
        if (mis_st) exc[14] = 1'b1;
        if (r.exc[16])              bad = r.pc;
        else if (mis_ld || mis_st)  bad = a;
        else                        bad = 32'h0;
        acc = r.en && r.pc != 0 && exc == 0;
        bus = {r.cp0, r.dslot, bad, exc, r.mem_op, r.hilo, r.pc, r.en, r.wen, r.sel, r.we,
               r.waddr, r.alu};
        wr    = (r.st_op != 0);
        strb  = 4'h0;
        wdata = 32'h0;
        if (r.st_op[2]) begin
            size = 2'd0; strb = 4'(1 << (a % 4)); wdata = 32'(r.rt[7:0]) * 32'h0101_0101;
        end else if (r.st_op[1]) begin
            size = 2'd1; strb = ((a / 2) % 2 != 0) ? 4'hC : 4'h3;
            wdata = 32'(r.rt[15:0]) * 32'h0001_0001;
        end else if (r.st_op[0]) begin
            size = 2'd2; strb = 4'hF; wdata = r.rt;
        end else if (r.mem_op[2] || r.mem_op[1]) begin
            size = 2'd1;
        end else if (r.mem_op[0]) begin
            size = 2'd2;
        end else begin
            size = 2'd0;
        end
    endfunction

    task automatic check_outputs();
        logic [249:0] eb;
        bit           acc, ewr, exp_stallreq;
        logic [1:0]   esz;
        logic [3:0]   est;
        logic [31:0]  ewd;
        expect_from(m_reg, eb, acc, esz, est, ewd, ewr);
        m_exp_req    = acc && !pending && !orphan && !served;
        exp_stallreq = acc && !served && !(pending && data_ok);
        check("req", 256'(data_sram_req), 256'(m_exp_req));
        check("stallreq", 256'(stallreq_dc), 256'(exp_stallreq));
        check("dc_to_mem_bus", 256'(dc_to_mem_bus), 256'(eb));
        if (m_exp_req) begin
            check("addr", 256'(data_sram_addr), 256'(m_reg.alu));
            check("wr", 256'(data_sram_wr), 256'(ewr));
            check("size", 256'(data_sram_size), 256'(esz));
            check("wstrb", 256'(data_sram_wstrb), 256'(est));
            check("wdata", 256'(data_sram_wdata), 256'(ewd));
        end
    endtask

    task automatic drive(input in_t bus, input bit r, input bit f, input bit exs, input bit dss,
                         input bit aok, input bit dok);
        @(negedge clk);
        ex_to_dc_bus = bus;
        rst = r; flush = f; ex_stop = exs; ds_stop = dss; addr_ok = aok; data_ok = dok;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        bit s5, s6, req_e;
        s5 = stall[5]; s6 = stall[6]; req_e = m_exp_req; cap_req = data_sram_req;
        @(posedge clk);
        if (rst) begin
            m_reg = '0; pending = 0; orphan = 0; served = 0;
        end else begin
            if (pending) begin
                if (data_ok) begin pending = 0; served = !flush && s6; end
                else if (flush) begin pending = 0; orphan = 1; end
            end else if (orphan) begin
                if (data_ok) orphan = 0;
            end else if (served) begin
                if (!s6 || flush) served = 0;
            end else if (req_e && addr_ok) begin
                if (flush) orphan = 1; else pending = 1;
            end
            if (flush)             m_reg = '0;
            else if (s5 && !s6)    m_reg = '0;
            else if (!s5)          m_reg = ex_to_dc_bus;
        end
    endtask

    initial begin
        in_t z, ia, ib;
        z = '0;
        rst = 1'b1; flush = 1'b0; ex_stop = 1'b0; ds_stop = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0;
        ex_to_dc_bus = mk(5, 32'h8000_0040, 32'h0, 32'hBFC0_0000, 32'h0);
        repeat (2) @(posedge clk);
        m_reg = '0; pending = 0; orphan = 0; served = 0;
        br_busy = 0; br_wait = 0;
        @(negedge clk);
        #1;
        check("rst_bus", 256'(dc_to_mem_bus), 256'(0));
        check("rst_req", 256'(data_sram_req), 256'(0));
        check("rst_stallreq", 256'(stallreq_dc), 256'(0));
        check("rst_attrs", 256'({data_sram_wr, data_sram_size, data_sram_wstrb,
                                 data_sram_addr, data_sram_wdata}), 256'(0));

        // aligned lw: accept on cycle 1, response on cycle 3
        ia = mk(5, 32'h8000_0010, 32'h0, 32'hBFC0_0100, 32'h0);
        drive(ia, 0, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 1, 0);
        check("lw_req_c1", 256'(data_sram_req), 256'(1));
        check("lw_size", 256'(data_sram_size), 256'(2));
        tick();
        drive(z, 0, 0, 0, 0, 0, 0);
        check("lw_req_c2", 256'(data_sram_req), 256'(0));
        check("lw_stallreq_c2", 256'(stallreq_dc), 256'(1));
        tick();
        drive(z, 0, 0, 0, 0, 0, 1);
        check("lw_stallreq_c3", 256'(stallreq_dc), 256'(0));
        check("lw_pc_out", 256'(dc_to_mem_bus[75:44]), 256'(32'hBFC0_0100));
        check("lw_bad_vaddr", 256'(dc_to_mem_bus[210:179]), 256'(0));
        tick();

        // sb lane replication on byte 3
        ia = mk(6, 32'h8000_0003, 32'h1234_5678, 32'hBFC0_0200, 32'h0);
        drive(ia, 0, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 1, 0);
        check("sb_wstrb", 256'(data_sram_wstrb), 256'(4'b1000));
        check("sb_wdata", 256'(data_sram_wdata), 256'(32'h7878_7878));
        check("sb_size", 256'(data_sram_size), 256'(0));
        check("sb_wr", 256'(data_sram_wr), 256'(1));
        tick();
        drive(z, 0, 0, 0, 0, 0, 1); tick();

        // misaligned lh
        ia = mk(3, 32'h8000_0001, 32'h0, 32'hBFC0_0300, 32'h0);
        drive(ia, 0, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 0, 0);
        check("lh_mis_req", 256'(data_sram_req), 256'(0));
        check("lh_mis_stallreq", 256'(stallreq_dc), 256'(0));
        check("lh_mis_exc15", 256'(dc_to_mem_bus[162]), 256'(1));
        check("lh_mis_bad_vaddr", 256'(dc_to_mem_bus[210:179]), 256'(32'h8000_0001));
        tick();

        // flush while waiting; the next lw is held back until the drain finishes
        ia = mk(5, 32'h8000_0020, 32'h0, 32'hBFC0_0400, 32'h0);
        ib = mk(5, 32'h8000_0024, 32'h0, 32'hBFC0_0380, 32'h0);
        drive(ia, 0, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 1, 0); tick();
        drive(ib, 0, 1, 0, 0, 0, 0); tick();
        drive(ib, 0, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 0, 1);
        check("drain_req_withheld", 256'(data_sram_req), 256'(0));
        check("drain_stallreq", 256'(stallreq_dc), 256'(1));
        tick();
        drive(z, 0, 0, 0, 0, 1, 0);
        check("post_drain_req", 256'(data_sram_req), 256'(1));
        check("post_drain_addr", 256'(data_sram_addr), 256'(32'h8000_0024));
        tick();
        drive(z, 0, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 0, 1); tick();

        // response while downstream is stalled
        ia = mk(5, 32'h8000_0030, 32'h0, 32'hBFC0_0500, 32'h0);
        ib = mk(8, 32'h8000_0034, 32'hCAFE_F00D, 32'hBFC0_0504, 32'h0);
        drive(ia, 0, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 1, 0); tick();
        drive(ib, 0, 0, 0, 1, 0, 1); tick();
        drive(ib, 0, 0, 0, 1, 0, 0);
        check("done_no_req", 256'(data_sram_req), 256'(0));
        check("done_stallreq", 256'(stallreq_dc), 256'(0));
        tick();
        drive(ib, 0, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 1, 0);
        check("after_done_req", 256'(data_sram_req), 256'(1));
        check("after_done_wdata", 256'(data_sram_wdata), 256'(32'hCAFE_F00D));
        tick();
        drive(z, 0, 0, 0, 0, 0, 1); tick();

        // reset with a request in flight
        ia = mk(7, 32'h8000_0042, 32'h0000_BEEF, 32'hBFC0_0600, 32'h0);
        drive(ia, 0, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 1, 0); tick();
        drive(z, 1, 0, 0, 0, 0, 0); tick();
        drive(z, 0, 0, 0, 0, 0, 0);
        check("rst_mid_req", 256'(data_sram_req), 256'(0));
        check("rst_mid_stallreq", 256'(stallreq_dc), 256'(0));
        tick();

        // randomized traffic with a bridge that answers 1..3 cycles after accept
        br_busy = 0; br_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit  f, r, exs, dss, aok, dok;
            in_t ins;
            ins = rand_instr();
            r   = ($urandom_range(0, 299) == 0);
            f   = ($urandom_range(0, 15) == 0);
            exs = ($urandom_range(0, 7) == 0);
            dss = ($urandom_range(0, 5) == 0);
            dok = br_busy && br_wait == 0;
            aok = !br_busy && !f && ($urandom_range(0, 1) == 1);
            drive(ins, r, f, exs, dss, aok, dok);
            tick();
            if (r) begin
                br_busy = 0;
            end else if (br_busy) begin
                if (dok) br_busy = 0;
                else     br_wait--;
            end else if (cap_req && aok) begin
                br_busy = 1;
                br_wait = int'($urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
